control_unit: RTL and testbench

//  Multi-cycle sequencer that consumes the 13-bit instructions held by the instruction unit (iu).

---
 rtl/control_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_control_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle sequencer driving iu, register file, ALU and data-memory handshake
// Every output is registered: it shows the decision taken in the previous cycle's state.
module control_unit #(
    parameter int PC_W        = 5,
    parameter int IR_W        = 13,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IR_W-1:0] ir_in,
    input  logic            zero_flag,
    input  logic            mem_ack,
    output logic            ir_load,
    output logic            pc_inc,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_target,
    output logic            rf_we,
    output logic [1:0]      rf_waddr,
    output logic [1:0]      rf_raddr_a,
    output logic [1:0]      rf_raddr_b,
    output logic [1:0]      alu_op,
    output logic [7:0]      imm,
    output logic            mem_req,
    output logic            mem_we,
    output logic            halted,
    output logic            fault,
    output logic [15:0]     retired
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_LDI  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_BR   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        rd_q, rd_d;
    logic              cond_q, cond_d;
    logic [7:0]        immf_q, immf_d;
    logic [PC_W-1:0]   tgt_q, tgt_d;
    logic [CNT_W-1:0]  wait_q, wait_d;

    logic              ir_load_q, ir_load_d;
    logic              pc_inc_q, pc_inc_d;
    logic              pc_load_q, pc_load_d;
    logic [PC_W-1:0]   pc_target_q, pc_target_d;
    logic              rf_we_q, rf_we_d;
    logic [1:0]        rf_waddr_q, rf_waddr_d;
    logic [1:0]        rf_raddr_a_q, rf_raddr_a_d;
    logic [1:0]        rf_raddr_b_q, rf_raddr_b_d;
    logic [1:0]        alu_op_q, alu_op_d;
    logic [7:0]        imm_q, imm_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic [15:0]       retired_q, retired_d;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rd_d         = rd_q;
        cond_d       = cond_q;
        immf_d       = immf_q;
        tgt_d        = tgt_q;
        wait_d       = wait_q;
        pc_target_d  = pc_target_q;
        rf_waddr_d   = rf_waddr_q;
        rf_raddr_a_d = rf_raddr_a_q;
        rf_raddr_b_d = rf_raddr_b_q;
        alu_op_d     = alu_op_q;
        imm_d        = imm_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        halted_d     = halted_q;
        fault_d      = fault_q;
        retired_d    = retired_q;
        ir_load_d    = 1'b0;
        pc_inc_d     = 1'b0;
        pc_load_d    = 1'b0;
        rf_we_d      = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_load_d = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                op_d         = ir_in[12:10];
                rd_d         = ir_in[9:8];
                cond_d       = ir_in[9];
                immf_d       = ir_in[7:0];
                tgt_d        = ir_in[PC_W-1:0];
                rf_raddr_a_d = ir_in[7:6];
                rf_raddr_b_d = ir_in[5:4];
                state_d      = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WB;
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        alu_op_d   = (op_q == OP_ADD) ? 2'b01 : 2'b10;
                        rf_we_d    = 1'b1;
                        rf_waddr_d = rd_q;
                        pc_inc_d   = 1'b1;
                    end
                    OP_LDI: begin
                        alu_op_d   = 2'b00;
                        imm_d      = immf_q;
                        rf_we_d    = 1'b1;
                        rf_waddr_d = rd_q;
                        pc_inc_d   = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        mem_req_d = 1'b1;
                        mem_we_d  = (op_q == OP_ST);
                        wait_d    = '0;
                        state_d   = S_MEM;
                    end
                    OP_BR: begin
                        if (!cond_q || zero_flag) begin
                            pc_load_d   = 1'b1;
                            pc_target_d = tgt_q;
                        end else begin
                            pc_inc_d = 1'b1;
                        end
                    end
                    OP_HALT: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: pc_inc_d = 1'b1;
                endcase
            end
            S_MEM: begin
                // ack wins over timeout, so an ack in the final allowed cycle still completes
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_WB;
                end else if (wait_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    fault_d   = 1'b1;
                    state_d   = S_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                retired_d = retired_q + 16'd1;
                if (op_q == OP_LD) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = rd_q;
                    alu_op_d   = 2'b11;
                end
                if (op_q == OP_LD || op_q == OP_ST) begin
                    pc_inc_d = 1'b1;
                end
                state_d = S_FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            op_q         <= OP_NOP;
            rd_q         <= '0;
            cond_q       <= 1'b0;
            immf_q       <= '0;
            tgt_q        <= '0;
            wait_q       <= '0;
            ir_load_q    <= 1'b0;
            pc_inc_q     <= 1'b0;
            pc_load_q    <= 1'b0;
            pc_target_q  <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_raddr_a_q <= '0;
            rf_raddr_b_q <= '0;
            alu_op_q     <= '0;
            imm_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            cond_q       <= cond_d;
            immf_q       <= immf_d;
            tgt_q        <= tgt_d;
            wait_q       <= wait_d;
            ir_load_q    <= ir_load_d;
            pc_inc_q     <= pc_inc_d;
            pc_load_q    <= pc_load_d;
            pc_target_q  <= pc_target_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_raddr_a_q <= rf_raddr_a_d;
            rf_raddr_b_q <= rf_raddr_b_d;
            alu_op_q     <= alu_op_d;
            imm_q        <= imm_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            halted_q     <= halted_d;
            fault_q      <= fault_d;
            retired_q    <= retired_d;
        end
    end

    assign ir_load    = ir_load_q;
    assign pc_inc     = pc_inc_q;
    assign pc_load    = pc_load_q;
    assign pc_target  = pc_target_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_raddr_a = rf_raddr_a_q;
    assign rf_raddr_b = rf_raddr_b_q;
    assign alu_op     = alu_op_q;
    assign imm        = imm_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign halted     = halted_q;
    assign fault      = fault_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] ir_in;
    logic        zero_flag;
    logic        mem_ack;
    logic        ir_load, pc_inc, pc_load, rf_we, mem_req, mem_we, halted, fault;
    logic [4:0]  pc_target;
    logic [1:0]  rf_waddr, rf_raddr_a, rf_raddr_b, alu_op;
    logic [7:0]  imm;
    logic [15:0] retired;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [12:0] ir;
        logic        zf;
        logic        we;
        logic [1:0]  waddr;
        logic [1:0]  alu;
        logic [7:0]  imm;
        logic        inc;
        logic        ld;
        logic [4:0]  tgt;
    } vec_t;

    vec_t vecs[7];
    vec_t sb_q[$];

    control_unit #(.PC_W(5), .IR_W(13), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .zero_flag(zero_flag), .mem_ack(mem_ack),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .alu_op(alu_op), .imm(imm), .mem_req(mem_req), .mem_we(mem_we),
        .halted(halted), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(logic [12:0] ir, logic zf, logic we, logic [1:0] waddr,
                                logic [1:0] alu, logic [7:0] im, logic inc, logic ld,
                                logic [4:0] tgt);
        vec_t v;
        v.ir = ir; v.zf = zf; v.we = we; v.waddr = waddr; v.alu = alu;
        v.imm = im; v.inc = inc; v.ld = ld; v.tgt = tgt;
        return v;
    endfunction

    task automatic wait_ir_load();
        for (int i = 0; i < 40; i++) begin
            if (ir_load) break;
            @(negedge clk);
        end
        chk("ir_load_seen", ir_load, 1);
    endtask

    task automatic check_wb(input vec_t e);
        chk("rf_we", rf_we, e.we);
        chk("pc_inc", pc_inc, e.inc);
        chk("pc_load", pc_load, e.ld);
        if (e.we) begin
            chk("rf_waddr", rf_waddr, e.waddr);
            chk("alu_op", alu_op, e.alu);
        end
        if (e.ir[12:10] == 3'b011) chk("imm", imm, e.imm);
        if (e.ld) chk("pc_target", pc_target, e.tgt);
    endtask

    task automatic run_vec(input vec_t v);
        logic [15:0] r0;
        wait_ir_load();
        ir_in = v.ir;
        zero_flag = v.zf;
        sb_q.push_back(v);
        r0 = retired;
        @(negedge clk);
        chk("raddr_a", rf_raddr_a, v.ir[7:6]);
        chk("raddr_b", rf_raddr_b, v.ir[5:4]);
        @(negedge clk);
        check_wb(sb_q.pop_front());
        @(negedge clk);
        chk("single_pulse", {rf_we, pc_inc, pc_load, ir_load}, 0);
        chk("retired_inc", retired, r0 + 16'd1);
        @(negedge clk);
        chk("ir_load_latency4", ir_load, 1);
    endtask

    // Runs a LD/ST and raises mem_ack during MEM cycle ack_at (0 = never); returns MEM cycles seen.
    task automatic run_mem(input logic [12:0] ir, input int ack_at, output int cnt);
        wait_ir_load();
        ir_in = ir;
        @(negedge clk);
        @(negedge clk);
        chk("mem_we_valid", mem_we, ir[10]);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (fault || !mem_req) break;
            cnt++;
            if (cnt == ack_at) mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
        end
    endtask

    initial begin
        int          cnt;
        logic [15:0] r0;
        logic        bad;
        vec_t        e;

        vecs[0] = mk(13'b011_01_10101010, 1'b0, 1'b1, 2'd1, 2'b00, 8'hAA, 1'b1, 1'b0, 5'd0);
        vecs[1] = mk(13'b001_11_01_10_0000, 1'b0, 1'b1, 2'd3, 2'b01, 8'h00, 1'b1, 1'b0, 5'd0);
        vecs[2] = mk(13'b010_10_11_00_0000, 1'b0, 1'b1, 2'd2, 2'b10, 8'h00, 1'b1, 1'b0, 5'd0);
        vecs[3] = mk(13'b000_00_00_00_0000, 1'b0, 1'b0, 2'd0, 2'b00, 8'h00, 1'b1, 1'b0, 5'd0);
        vecs[4] = mk(13'b110_0_0000_01001, 1'b1, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 1'b1, 5'd9);
        vecs[5] = mk(13'b110_1_0000_10001, 1'b1, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 1'b1, 5'd17);
        vecs[6] = mk(13'b110_1_0000_10001, 1'b0, 1'b0, 2'd0, 2'b00, 8'h00, 1'b1, 1'b0, 5'd0);

        reset = 1'b0; ir_in = '0; zero_flag = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_strobes", {ir_load, pc_inc, pc_load, rf_we, mem_req, mem_we, halted, fault}, 0);
        chk("reset_retired", retired, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("first_ir_load", ir_load, 1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // LD r2,[r3] acked in the third MEM cycle
        r0 = retired;
        sb_q.push_back(mk(13'b100_10_11_000000, 1'b0, 1'b1, 2'd2, 2'b11, 8'h00, 1'b1, 1'b0, 5'd0));
        run_mem(13'b100_10_11_000000, 3, cnt);
        chk("ld_mem_cycles", cnt, 3);
        chk("ld_raddr_a", rf_raddr_a, 3);
        chk("ld_wb_not_yet", rf_we, 0);
        @(negedge clk);
        check_wb(sb_q.pop_front());
        chk("ld_retired", retired, r0 + 16'd1);

        // ST acked on the last allowed MEM cycle: no fault
        r0 = retired;
        sb_q.push_back(mk(13'b101_00_01_10_0000, 1'b0, 1'b0, 2'd0, 2'b00, 8'h00, 1'b1, 1'b0, 5'd0));
        run_mem(13'b101_00_01_10_0000, 15, cnt);
        chk("st_ack15_cycles", cnt, 15);
        chk("st_ack15_nofault", fault, 0);
        @(negedge clk);
        check_wb(sb_q.pop_front());
        chk("st_ack15_retired", retired, r0 + 16'd1);

        // ST never acked: timeout fault
        r0 = retired;
        run_mem(13'b101_00_01_10_0000, 0, cnt);
        chk("timeout_cycles", cnt, 15);
        chk("timeout_fault", fault, 1);
        chk("timeout_mem_req", mem_req, 0);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_ack = (i == 3);
            @(negedge clk);
            bad |= ir_load | pc_inc | pc_load | rf_we | mem_req;
        end
        mem_ack = 1'b0;
        chk("fault_no_strobes", bad, 0);
        chk("fault_retired_frozen", retired, r0);
        chk("fault_sticky", fault, 1);
        reset = 1'b0;
        #1;
        chk("fault_cleared_by_reset", fault, 0);
        @(negedge clk);
        reset = 1'b1;

        // reset asserted mid-MEM drops mem_req without waiting for a clock
        wait_ir_load();
        ir_in = 13'b100_01_10_000000;
        repeat (3) @(negedge clk);
        chk("midmem_req_high", mem_req, 1);
        reset = 1'b0;
        #1;
        chk("midmem_req_dropped", mem_req, 0);
        chk("midmem_retired_zero", retired, 0);
        @(negedge clk);
        reset = 1'b1;

        // HALT is terminal
        run_vec(vecs[0]);
        wait_ir_load();
        ir_in = 13'b111_0000000000;
        r0 = retired;
        @(negedge clk);
        @(negedge clk);
        chk("halted", halted, 1);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mem_ack = i[0];
            @(negedge clk);
            bad |= ir_load | pc_inc | pc_load | rf_we | mem_req;
        end
        mem_ack = 1'b0;
        chk("halt_no_strobes", bad, 0);
        chk("halt_retired_frozen", retired, r0);
        chk("halt_sticky", halted, 1);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
